// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, opcode class enum and decoded-record struct.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OP_IMM  = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd15
    } opclass_e;

    // XLEN-wide pc/immediate are kept outside the struct so it stays width-independent
    typedef struct packed {
        opclass_e   cls;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       illegal;
    } dec_rec_t;

    function automatic opclass_e classify(input logic [6:0] opc);
        case (opc)
            OPC_OP:     return CLS_OP;
            OPC_OP_IMM: return CLS_OP_IMM;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            default:    return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    opclass_e        out_class;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_class, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_class, out_illegal
    );
endinterface

// File: rtl/instr_fields.sv
// Combinational field, class and sign-extended immediate extraction for one instruction.
module instr_fields #(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr_i,
    output decode_pkg::dec_rec_t rec_o,
    output logic [XLEN-1:0]      imm_o
);
    import decode_pkg::*;

    opclass_e          cls;
    logic              f7_ok;
    logic signed [31:0] imm32;

    always_comb begin
        cls   = classify(instr_i[6:0]);
        f7_ok = (instr_i[31:25] == 7'b0000000) || (instr_i[31:25] == 7'b0100000);
        imm32 = '0;
        // Every format fits in 32 bits with instr[31] as its sign bit
        case (cls)
            CLS_OP_IMM, CLS_LOAD, CLS_JALR:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            CLS_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            CLS_BRANCH:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            CLS_JAL:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            default:
                imm32 = '0;
        endcase

        rec_o         = '0;
        rec_o.cls     = cls;
        rec_o.rd      = instr_i[11:7];
        rec_o.rs1     = instr_i[19:15];
        rec_o.rs2     = instr_i[24:20];
        rec_o.funct3  = instr_i[14:12];
        rec_o.funct7  = instr_i[31:25];
        rec_o.illegal = (instr_i[1:0] != 2'b11) || (cls == CLS_ILLEGAL) ||
                        ((cls == CLS_OP) && !f7_ok);
    end

    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes each fetched instruction and queues the record in a DEPTH-entry FIFO.
// Accept-to-out_valid latency is one cycle; in_ready drops whenever the queue is full.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus,
    output logic [15:0]   illegal_count
);
    import decode_pkg::*;

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    dec_rec_t        rec_new;
    logic [XLEN-1:0] imm_new;

    dec_rec_t        rec_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] imm_mem [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] occ_q, occ_d;
    logic [15:0]     icnt_q, icnt_d;
    logic            push, pop;
    dec_rec_t        head;

    instr_fields #(.XLEN(XLEN)) u_fields (
        .instr_i (bus.in_instr),
        .rec_o   (rec_new),
        .imm_o   (imm_new)
    );

    // Readiness depends only on registered occupancy: a same-cycle pop never frees a full queue
    assign bus.in_ready  = (occ_q < CNTW'(DEPTH));
    assign bus.out_valid = (occ_q != '0);
    assign push          = bus.in_valid && bus.in_ready && !flush;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        icnt_d   = icnt_q;
        if (push && rec_new.illegal && (icnt_q != 16'hFFFF)) begin
            icnt_d = icnt_q + 16'd1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
            occ_d = occ_q + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            icnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            icnt_q   <= icnt_d;
        end
    end

    // Payload storage is intentionally left unreset; occupancy alone gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            rec_mem[wr_ptr_q] <= rec_new;
            pc_mem[wr_ptr_q]  <= bus.in_pc;
            imm_mem[wr_ptr_q] <= imm_new;
        end
    end

    assign head           = rec_mem[rd_ptr_q];
    assign bus.out_pc      = pc_mem[rd_ptr_q];
    assign bus.out_imm     = imm_mem[rd_ptr_q];
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_funct3  = head.funct3;
    assign bus.out_funct7  = head.funct7;
    assign bus.out_class   = head.cls;
    assign bus.out_illegal = head.illegal;
    assign illegal_count   = icnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: two decode stages (XLEN 32 and 64, DEPTH 2) driven by one stream.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        opclass_e    cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b0;
    logic [15:0] icnt32, icnt64;

    int   checks = 0;
    int   fails  = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) b32 ();
    decode_stage_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.in_pc     = in_pc[31:0];
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.in_pc     = in_pc;
    assign b64.out_ready = out_ready;

    decode_stage #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .illegal_count(icnt32));
    decode_stage #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64), .illegal_count(icnt64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder written straight from the instruction-format rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        logic signed [11:0] i_imm;
        logic signed [11:0] s_imm;
        logic signed [12:0] b_imm;
        logic signed [20:0] j_imm;
        logic signed [31:0] u_imm;
        e = '0;
        e.pc = pc;
        e.rd = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3 = ins[14:12];
        e.f7 = ins[31:25];
        i_imm = ins[31:20];
        s_imm = {ins[31:25], ins[11:7]};
        b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        u_imm = {ins[31:12], 12'h000};
        case (ins[6:0])
            7'b0110011: begin e.cls = CLS_OP; e.ill = !(ins[31:25] == 7'd0 || ins[31:25] == 7'd32); end
            7'b0010011: begin e.cls = CLS_OP_IMM; e.imm = 64'(i_imm); end
            7'b0000011: begin e.cls = CLS_LOAD;   e.imm = 64'(i_imm); end
            7'b1100111: begin e.cls = CLS_JALR;   e.imm = 64'(i_imm); end
            7'b0100011: begin e.cls = CLS_STORE;  e.imm = 64'(s_imm); end
            7'b1100011: begin e.cls = CLS_BRANCH; e.imm = 64'(b_imm); end
            7'b1101111: begin e.cls = CLS_JAL;    e.imm = 64'(j_imm); end
            7'b0110111: begin e.cls = CLS_LUI;    e.imm = 64'(u_imm); end
            7'b0010111: begin e.cls = CLS_AUIPC;  e.imm = 64'(u_imm); end
            default:    begin e.cls = CLS_ILLEGAL; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: opc = OPC_OP;
            1: opc = OPC_OP_IMM;
            2: opc = OPC_LOAD;
            3: opc = OPC_STORE;
            4: opc = OPC_BRANCH;
            5: opc = OPC_JAL;
            6: opc = OPC_JALR;
            7: opc = OPC_LUI;
            8: opc = OPC_AUIPC;
            9: begin opc = OPC_OP; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            default: opc = r[6:0];
        endcase
        return {r[31:7], opc};
    endfunction

    task automatic cmp_head(input string t, input exp_t e, input logic [63:0] mask,
                            input logic [63:0] pc, input logic [63:0] imm, input logic [3:0] cls,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic ill);
        chk({t, "_pc"}, pc, e.pc & mask);
        chk({t, "_imm"}, imm, e.imm & mask);
        chk({t, "_class"}, cls, e.cls);
        chk({t, "_rd"}, rd, e.rd);
        chk({t, "_rs1"}, rs1, e.rs1);
        chk({t, "_rs2"}, rs2, e.rs2);
        chk({t, "_funct3"}, f3, e.f3);
        chk({t, "_funct7"}, f7, e.f7);
        chk({t, "_illegal"}, ill, e.ill);
    endtask

    // Monitor: checks handshake state against the model and compares every popped record
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid32", b32.out_valid, q32.size() != 0);
            chk("valid64", b64.out_valid, q64.size() != 0);
            chk("ready32", b32.in_ready, q32.size() < 2);
            chk("ready64", b64.in_ready, q64.size() < 2);
            chk("icnt32", icnt32, exp_cnt);
            chk("icnt64", icnt64, exp_cnt);
            if (b32.out_valid && b32.out_ready) begin
                if (q32.size() == 0) chk("extra_out32", 1, 0);
                else begin
                    e32 = q32.pop_front();
                    cmp_head("out32", e32, 64'hFFFF_FFFF, b32.out_pc, b32.out_imm, b32.out_class,
                             b32.out_rd, b32.out_rs1, b32.out_rs2, b32.out_funct3,
                             b32.out_funct7, b32.out_illegal);
                end
            end
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) chk("extra_out64", 1, 0);
                else begin
                    e64 = q64.pop_front();
                    cmp_head("out64", e64, '1, b64.out_pc, b64.out_imm, b64.out_class,
                             b64.out_rd, b64.out_rs1, b64.out_rs2, b64.out_funct3,
                             b64.out_funct7, b64.out_illegal);
                end
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1; expectations are queued on acceptance
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit rdy, input bit fl, output bit acc);
        exp_t e;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        acc = 1'b0;
        @(negedge clk); #1;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else if (v && b32.in_ready) begin
            acc = 1'b1;
            e = ref_decode(ins, pc);
            q32.push_back(e);
            q64.push_back(e);
            if (e.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc, input bit rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, ins, pc, rdy, 1'b0, acc);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: instr %08h not accepted within %0d cycles", ins, n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    logic [31:0] d_ins [6];
    opclass_e    d_cls [6];
    logic [4:0]  d_rd  [6];
    logic [63:0] d_imm [6];
    logic        d_ill [6];

    initial begin
        bit acc;
        d_ins = '{32'hFFF00093, 32'h123452B7, 32'h0080006F, 32'hFE000EE3, 32'h00000000, 32'h0000007F};
        d_cls = '{CLS_OP_IMM, CLS_LUI, CLS_JAL, CLS_BRANCH, CLS_ILLEGAL, CLS_ILLEGAL};
        d_rd  = '{5'd1, 5'd5, 5'd0, 5'd29, 5'd0, 5'd0};
        d_imm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5000, 64'd8,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0};
        d_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid32", b32.out_valid, 0);
        chk("rst_valid64", b64.out_valid, 0);
        chk("rst_icnt32", icnt32, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed decodes, each checked one cycle after acceptance
        for (int k = 0; k < 6; k++) begin
            send(d_ins[k], 64'h8000_0000_0000_1000 + 64'(k * 4), 1'b0);
            @(negedge clk); #2;
            chk("lat_valid", b32.out_valid, 1);
            chk("d_class32", b32.out_class, d_cls[k]);
            chk("d_class64", b64.out_class, d_cls[k]);
            chk("d_rd", b64.out_rd, d_rd[k]);
            chk("d_imm32", b32.out_imm, d_imm[k] & 64'hFFFF_FFFF);
            chk("d_imm64", b64.out_imm, d_imm[k]);
            chk("d_illegal", b64.out_illegal, d_ill[k]);
            @(posedge clk); #1;
            idle(1);
        end
        chk("icnt_two", icnt32, 2);

        // Backpressure: third instruction is held until the execute side drains
        send(32'h00500113, 64'h100, 1'b0);
        send(32'h00A00193, 64'h104, 1'b0);
        chk("full_ready", b32.in_ready, 0);
        cycle(1'b1, 32'h40208233, 64'h108, 1'b0, 1'b0, acc);
        chk("held", acc, 0);
        cycle(1'b1, 32'h40208233, 64'h108, 1'b0, 1'b0, acc);
        chk("held2", acc, 0);
        send(32'h40208233, 64'h108, 1'b1);
        idle(4);

        // Flush with a full queue, then with one entry and a concurrent input
        send(32'h00112023, 64'h200, 1'b0);
        send(32'h00212223, 64'h204, 1'b0);
        cycle(1'b1, 32'h00312423, 64'h208, 1'b0, 1'b1, acc);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk); #2;
        chk("flush_full_valid", b32.out_valid, 0);
        @(posedge clk); #1;
        send(32'h00412623, 64'h20C, 1'b0);
        cycle(1'b1, 32'h00512823, 64'h210, 1'b0, 1'b1, acc);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk); #2;
        chk("flush_drop_valid", b64.out_valid, 0);
        @(posedge clk); #1;
        idle(2);

        // Asynchronous reset with records queued
        send(32'h0000007F, 64'h300, 1'b0);
        send(32'h00000001, 64'h304, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid32", b32.out_valid, 0);
        chk("arst_valid64", b64.out_valid, 0);
        chk("arst_icnt", icnt64, 0);
        q32.delete(); q64.delete(); exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 3) != 0), gen_instr(), {$urandom, $urandom},
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), acc);
        end
        flush = 1'b0;
        idle(4);

        // Enough illegal instructions to saturate the counter from any prior value
        for (int k = 0; k < 65600; k++) cycle(1'b1, 32'h0, 64'(k), 1'b1, 1'b0, acc);
        idle(3);
        chk("sat32", icnt32, 16'hFFFF);
        chk("sat64", icnt64, 16'hFFFF);
        chk("drain32", q32.size(), 0);
        chk("drain64", q64.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-record queue depth; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous queue clear.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1  fetch-side handshake.
REQ-007 SHALL have ports in_instr input 32 / in_pc input XLEN  raw instruction and its address.
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1  execute-side handshake.
REQ-009 SHALL have ports out_pc output XLEN, out_rd/out_rs1/out_rs2 output 5, out_funct3 output 3, out_funct7 output 7  decoded fields of queue head.
REQ-010 SHALL have port out_imm  output XLEN  sign-extended immediate of queue head.
REQ-011 SHALL have port out_class  output 4  opcode class enum of queue head.
REQ-012 SHALL have port out_illegal  output 1  head instruction is illegal.
REQ-013 SHALL have port illegal_count  output 16  saturating count of illegal instructions accepted.

Function
REQ-014 SHALL accept an input when in_valid && in_ready; SHALL present a decoded record when out_valid, consumed when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (occupancy < DEPTH); no pass-through when full, even if the head pops the same cycle.
REQ-016 SHALL decode combinationally on input and write the record into the queue; latency from accept to out_valid = 1 cycle when queue is empty.
REQ-017 SHALL support simultaneous push and pop when not full; occupancy unchanged; order strictly FIFO.
REQ-018 SHALL keep read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy counter 0..DEPTH.
REQ-019 SHALL classify opcodes: OP(0110011), OP_IMM(0010011), LOAD(0000011), STORE(0100011), BRANCH(1100011), JAL(1101111), JALR(1100111), LUI(0110111), AUIPC(0010111); all others ILLEGAL.
REQ-020 SHALL form immediates: I (OP_IMM, LOAD, JALR) = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; U = {instr[31:12],12'b0}; all sign-extended from instr[31] to XLEN; OP and ILLEGAL give 0.
REQ-021 SHALL flag illegal when instr[1:0] != 2'b11, opcode unrecognised, or class OP with funct7 not 0000000/0100000; illegal records SHALL still be queued in order with out_imm = 0.
REQ-022 SHALL increment illegal_count on each accepted illegal instruction, saturating at 0xFFFF.
REQ-023 On flush SHALL clear occupancy and pointers next edge; an input presented in the flush cycle SHALL be dropped; a pop in that cycle is still a pop; illegal_count not affected.
REQ-024 SHALL hold all out_* stable while out_valid && !out_ready.

Reset
REQ-025 SHALL on rst_n low immediately set occupancy 0, pointers 0, out_valid 0, illegal_count 0; in_ready reads 1 after reset release.
REQ-026 SHALL discard any queued records when reset is asserted mid-operation; queue payload storage need not be reset.

Structure
REQ-027 SHALL place the opcode constants, the 4-bit opclass enum and the decoded-record struct type in shared package decode_pkg.
REQ-028 SHALL implement field/immediate extraction as combinational sub-module instr_fields (XLEN parameter); queue and counters in decode_stage.

Verification
REQ-029 Push 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> next cycle out_valid=1, class OP_IMM, rd=1, imm=0xFFFFFFFF.
REQ-030 Push 0x123452B7 with XLEN=64 -> imm=0x0000000012345000, rd=5, class LUI; 0x0080006F -> class JAL, imm=8; 0xFE000EE3 -> class BRANCH, imm=-4.
REQ-031 DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after second accept; third held; release out_ready -> outputs in order, no loss.
REQ-032 Push 0x00000000 and 0x0000007F -> both out_illegal=1, imm=0, illegal_count=2; force 65536 illegals -> count stays 0xFFFF.
REQ-033 Queue holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy 0, flushed-cycle input absent; assert rst_n=0 mid-stream -> out_valid=0 without a clock edge.
